// File: rtl/program_loader_if.sv
// program_loader_if: host byte stream, memory write ports and core control of the loader
interface program_loader_if #(parameter int ADDR_W = 10);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              done;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_addr;
    logic              ins_we;
    logic [31:0]       data;
    logic [ADDR_W-1:0] data_addr;
    logic              data_we;
    logic              cpu_rst;
    logic              running;
    logic              halted;
    logic              err;
    modport master (
        input  in_valid, in_data, done,
        output in_ready, instr, instr_addr, ins_we, data, data_addr, data_we,
               cpu_rst, running, halted, err
    );
    modport slave (
        output in_valid, in_data, done,
        input  in_ready, instr, instr_addr, ins_we, data, data_addr, data_we,
               cpu_rst, running, halted, err
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: assembles host bytes into words, writes instr/data memories, runs the core
module program_loader #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 2 ** ADDR_W,
    parameter int TIMEOUT = 4095
) (
    input logic             clk,
    input logic             rst_n,
    program_loader_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_CNT_HI, S_CNT_LO, S_WORD, S_WRITE, S_RUN, S_ERR} state_t;

    state_t            state, state_nx;
    logic [31:0]       word;
    logic [ADDR_W-1:0] addr;
    logic [RW-1:0]     remaining;
    logic [1:0]        byte_idx;
    logic              sect;
    logic [7:0]        cnt_hi;
    logic [TW-1:0]     idle_cnt;
    logic              halted_r;
    logic              hs;
    logic              counting;
    logic              timed_out;
    logic [15:0]       cnt;

    assign hs        = bus.in_valid & bus.in_ready;
    assign cnt       = {cnt_hi, bus.in_data};
    assign counting  = state inside {S_CNT_HI, S_CNT_LO, S_WORD};
    assign timed_out = counting && !hs && idle_cnt == TW'(TIMEOUT - 1);

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;

    // Next state and decoded outputs; an idle timeout overrides any frame progress
    always_comb begin
        state_nx       = state;
        bus.in_ready   = rst_n && state != S_WRITE;
        bus.ins_we     = state == S_WRITE && !sect;
        bus.data_we    = state == S_WRITE && sect;
        bus.cpu_rst    = state != S_RUN;
        bus.running    = state == S_RUN && !halted_r;
        bus.halted     = halted_r;
        bus.err        = state == S_ERR;
        bus.instr      = word;
        bus.data       = word;
        bus.instr_addr = addr;
        bus.data_addr  = addr;
        case (state)
            S_IDLE:   if (hs) state_nx = bus.in_data inside {8'h01, 8'h02} ? S_CNT_HI :
                                         bus.in_data == 8'h03 ? S_RUN : S_ERR;
            S_CNT_HI: if (hs) state_nx = S_CNT_LO;
            S_CNT_LO: if (hs) state_nx = cnt == 16'd0 ? S_IDLE :
                                         cnt > 16'(DEPTH) ? S_ERR : S_WORD;
            S_WORD:   if (hs && byte_idx == 2'd3) state_nx = S_WRITE;
            S_WRITE:  state_nx = remaining == RW'(1) ? S_IDLE : S_WORD;
            S_RUN:    if (hs && bus.in_data == 8'hA5) state_nx = S_IDLE;
            default:  state_nx = S_ERR;
        endcase
        if (timed_out) state_nx = S_ERR;
    end

    // Frame datapath: section, count, word shifter, address walk, idle counter, halt flag
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            word      <= '0;
            addr      <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            sect      <= 1'b0;
            cnt_hi    <= '0;
            idle_cnt  <= '0;
            halted_r  <= 1'b0;
        end else begin
            idle_cnt <= (!counting || hs) ? '0 : idle_cnt + TW'(1);
            if (hs && state == S_IDLE) sect <= bus.in_data[1];
            if (hs && state == S_CNT_HI) cnt_hi <= bus.in_data;
            if (hs && state == S_CNT_LO) begin
                addr      <= '0;
                remaining <= RW'(cnt);
                byte_idx  <= '0;
            end
            if (hs && state == S_WORD) begin
                word     <= {bus.in_data, word[31:8]};
                byte_idx <= byte_idx + 2'd1;
            end
            if (state == S_WRITE) begin
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - RW'(1);
            end
            if (state == S_RUN)
                halted_r <= (hs && bus.in_data == 8'hA5) ? 1'b0 : halted_r | bus.done;
        end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized frame loading checked against an expected write list
module tb_program_loader;
    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 1024;
    localparam int TIMEOUT = 4095;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    program_loader_if #(.ADDR_W(ADDR_W)) bus();
    program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct packed {logic sec; logic [ADDR_W-1:0] addr; logic [31:0] d;} wr_t;
    wr_t exp_q[$];
    wr_t obs_q[$];
    logic [31:0] words[$];
    int tests = 0;
    int fails = 0;
    int bad_ready = 0;

    always @(negedge clk) begin
        if (bus.ins_we) obs_q.push_back('{1'b0, bus.instr_addr, bus.instr});
        if (bus.data_we) obs_q.push_back('{1'b1, bus.data_addr, bus.data});
        if ((bus.ins_we || bus.data_we) && bus.in_ready) bad_ready++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", 64'(t < 20), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic load(input logic sec, input int gap_max);
        int n = words.size();
        send(sec ? 8'h02 : 8'h01);
        send(8'(n >> 8));
        send(8'(n));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{sec, ADDR_W'(i), words[i]});
            for (int b = 0; b < 4; b++) begin
                send(words[i][8*b +: 8]);
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
            end
        end
    endtask

    task automatic compare_writes(input string tag);
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < obs_q.size()) check(tag, 64'(obs_q[i]), 64'(exp_q[i]));
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.done     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        check("rst_we", 64'({bus.ins_we, bus.data_we}), 64'd0);
        check("rst_addr", 64'({bus.instr_addr, bus.data_addr}), 64'd0);
        check("rst_words", 64'({bus.instr, bus.data}), 64'd0);
        check("rst_flags", 64'({bus.running, bus.halted, bus.err}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 64'(bus.in_ready), 64'd1);

        words = '{32'h12345678, 32'hDEADBEEF};
        load(1'b0, 0);
        compare_writes("t1_instr");
        check("t1_cpu_rst", 64'(bus.cpu_rst), 64'd1);

        for (int k = 0; k < 6; k++) begin
            words.delete();
            repeat ($urandom_range(1, 6)) words.push_back($urandom);
            load(1'($urandom_range(0, 1)), $urandom_range(0, 2));
            compare_writes("rand_frame");
        end

        words = '{32'h00000004};
        load(1'b1, 0);
        compare_writes("t2_data");
        send(8'h03);
        check("run_cpu_rst", 64'(bus.cpu_rst), 64'd0);
        check("run_running", 64'({bus.running, bus.halted}), 64'b10);
        send(8'h11);
        send(8'h01);
        send(8'h00);
        compare_writes("run_drop");
        check("run_still", 64'(bus.cpu_rst), 64'd0);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        check("halt_flags", 64'({bus.running, bus.halted, bus.cpu_rst}), 64'b010);

        send(8'hA5);
        check("a5_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        check("a5_flags", 64'({bus.running, bus.halted, bus.in_ready}), 64'b001);
        send(8'h01);
        send(8'h00);
        send(8'h00);
        compare_writes("n0_none");
        words = '{32'($urandom)};
        load(1'b0, 1);
        compare_writes("after_n0");
        check("write_ready_low", 64'(bad_ready), 64'd0);

        send(8'h01);
        send(8'h04);
        send(8'h01);
        check("oversize_err", 64'({bus.err, bus.in_ready}), 64'b11);
        repeat (8) send(8'($urandom));
        check("err_sticky", 64'({bus.err, bus.in_ready, bus.cpu_rst}), 64'b111);
        compare_writes("err_drop");

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("err_cleared", 64'({bus.err, bus.in_ready}), 64'b01);
        send(8'h01);
        send(8'h00);
        send(8'h01);
        send(8'h78);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("timeout_before", 64'(bus.err), 64'd0);
        @(negedge clk);
        check("timeout_err", 64'(bus.err), 64'd1);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h01);
        send(8'h00);
        send(8'h01);
        send(8'hAA);
        send(8'hBB);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(bus.in_ready), 64'd0);
        check("midrst_ctl", 64'({bus.cpu_rst, bus.ins_we, bus.err, bus.running}), 64'b1000);
        check("midrst_bus", 64'({bus.instr, bus.instr_addr}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        words = '{32'($urandom), 32'($urandom)};
        load(1'b0, 0);
        compare_writes("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
